// File: rtl/sync_box_pkg.sv
// Shared state and instruction-type codes for the two-core arbiter and reservation unit.
package sync_box_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_OWN_P0 = 2'b01,
      ST_OWN_P1 = 2'b10
   } state_t;

   typedef logic [1:0] itype_t;

   localparam itype_t IT_PLAIN = 2'b00;
   localparam itype_t IT_LL    = 2'b01;
   localparam itype_t IT_SC    = 2'b10;

   // A completed access kills a matching foreign reservation if it really wrote memory.
   function automatic logic snoops_other(input logic wr_n, input itype_t itype, input logic sc_ok);
      if (itype == IT_SC) return sc_ok;
      return !wr_n;
   endfunction

endpackage

// File: rtl/sync_box_if.sv
// Core-side request/grant bundle between the two DLX cores and the arbiter.
interface sync_box_if
   import sync_box_pkg::*;
#(
   parameter int ADDR_W = 32
);
   logic              req_P0, req_P1;
   logic              trigger_P0, trigger_P1;
   itype_t            instr_type_P0, instr_type_P1;
   logic [ADDR_W-1:0] MAR_P0, MAR_P1;
   logic              WR_N_P0, WR_N_P1;
   logic              P0_mem_complete, P1_mem_complete;
   logic              P0_in_init, P1_in_init;
   logic              P0_pass, P1_pass;
   logic              P0_success, P1_success;
   logic              mem_owner;
   logic              wdog_err;

   modport master (
      output req_P0, req_P1, trigger_P0, trigger_P1, instr_type_P0, instr_type_P1,
             MAR_P0, MAR_P1, WR_N_P0, WR_N_P1, P0_mem_complete, P1_mem_complete,
             P0_in_init, P1_in_init,
      input  P0_pass, P1_pass, P0_success, P1_success, mem_owner, wdog_err
   );

   modport slave (
      input  req_P0, req_P1, trigger_P0, trigger_P1, instr_type_P0, instr_type_P1,
             MAR_P0, MAR_P1, WR_N_P0, WR_N_P1, P0_mem_complete, P1_mem_complete,
             P0_in_init, P1_in_init,
      output P0_pass, P1_pass, P0_success, P1_success, mem_owner, wdog_err
   );
endinterface

// File: rtl/sync_res_slot.sv
// One LL reservation: valid flag plus word address, with clears taking priority over set.
module sync_res_slot #(
   parameter int AW = 30
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          set,
   input  logic          own_clear,
   input  logic          snoop_clear,
   input  logic [AW-1:0] addr,
   output logic          match,
   output logic          valid
);

   logic [AW-1:0] res_a;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
      end else if (own_clear || snoop_clear) begin
         valid <= 1'b0;
      end else if (set) begin
         valid <= 1'b1;
      end
   end

   // The address is only meaningful while valid, so it carries no reset.
   always_ff @(posedge clk) begin
      if (set && !own_clear && !snoop_clear) res_a <= addr;
   end

   assign match = valid && (res_a == addr);

endmodule

// File: rtl/sync_box.sv
// Two-core RAM arbiter: round-robin grant FSM, watchdog and LL/SC reservation tracking.
module sync_box
   import sync_box_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int RES_LSB = 2,
   parameter int WDOG_W  = 8
) (
   input logic     clk,
   input logic     reset,
   sync_box_if.slave bus
);

   localparam int WA_W = ADDR_W - RES_LSB;
   localparam logic [WDOG_W-1:0] WDOG_LAST = ~(WDOG_W'(1));

   state_t            state, next_state;
   logic              last_owner;
   logic [WDOG_W-1:0] wdog;
   logic              wdog_err_r;
   logic              succ0, succ1;

   logic              own0, own1, comp0, comp1, elig0, elig1, wdog_hit;
   logic [WA_W-1:0]   own_addr;
   itype_t            itype;
   logic              wr_n, owner_succ, snoop_kind;
   logic              set0, set1, oclr0, oclr1, sclr0, sclr1;
   logic              match0, match1, valid0, valid1;

   assign own0     = (state == ST_OWN_P0);
   assign own1     = (state == ST_OWN_P1);
   assign comp0    = own0 && bus.P0_mem_complete;
   assign comp1    = own1 && bus.P1_mem_complete;
   assign elig0    = bus.req_P0 && !bus.P0_in_init;
   assign elig1    = bus.req_P1 && !bus.P1_in_init;
   assign wdog_hit = (wdog == WDOG_LAST);

   // Only the bus owner can complete, so both slots compare against the owner's word address.
   assign own_addr   = own1 ? bus.MAR_P1[ADDR_W-1:RES_LSB] : bus.MAR_P0[ADDR_W-1:RES_LSB];
   assign itype      = own1 ? bus.instr_type_P1 : bus.instr_type_P0;
   assign wr_n       = own1 ? bus.WR_N_P1 : bus.WR_N_P0;
   assign owner_succ = own1 ? succ1 : succ0;
   assign snoop_kind = snoops_other(wr_n, itype, owner_succ);

   assign set0  = comp0 && (itype == IT_LL);
   assign set1  = comp1 && (itype == IT_LL);
   assign oclr0 = bus.P0_in_init || (comp0 && (itype == IT_SC));
   assign oclr1 = bus.P1_in_init || (comp1 && (itype == IT_SC));
   assign sclr0 = comp1 && snoop_kind && match0;
   assign sclr1 = comp0 && snoop_kind && match1;

   sync_res_slot #(.AW(WA_W)) u_slot0 (
      .clk(clk), .reset(reset), .set(set0), .own_clear(oclr0), .snoop_clear(sclr0),
      .addr(own_addr), .match(match0), .valid(valid0)
   );

   sync_res_slot #(.AW(WA_W)) u_slot1 (
      .clk(clk), .reset(reset), .set(set1), .own_clear(oclr1), .snoop_clear(sclr1),
      .addr(own_addr), .match(match1), .valid(valid1)
   );

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (elig0 && (!elig1 || last_owner)) next_state = ST_OWN_P0;
            else if (elig1)                      next_state = ST_OWN_P1;
         end
         ST_OWN_P0: if (bus.P0_mem_complete || bus.P0_in_init || wdog_hit) next_state = ST_IDLE;
         ST_OWN_P1: if (bus.P1_mem_complete || bus.P1_in_init || wdog_hit) next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         last_owner <= 1'b1;
         wdog       <= '0;
         wdog_err_r <= 1'b0;
         succ0      <= 1'b0;
         succ1      <= 1'b0;
      end else begin
         state <= next_state;
         if (comp0) last_owner <= 1'b0;
         if (comp1) last_owner <= 1'b1;
         wdog <= (own0 || own1) ? wdog + 1'b1 : '0;
         if ((own0 || own1) && wdog_hit && !(comp0 || comp1)) wdog_err_r <= 1'b1;
         // SC result is held for the rest of the grant and dropped as it ends.
         if (own0 && next_state == ST_OWN_P0) begin
            if (bus.trigger_P0) succ0 <= match0;
         end else begin
            succ0 <= 1'b0;
         end
         if (own1 && next_state == ST_OWN_P1) begin
            if (bus.trigger_P1) succ1 <= match1;
         end else begin
            succ1 <= 1'b0;
         end
      end
   end

   assign bus.P0_pass    = own0;
   assign bus.P1_pass    = own1;
   assign bus.mem_owner  = own1;
   assign bus.P0_success = succ0;
   assign bus.P1_success = succ1;
   assign bus.wdog_err   = wdog_err_r;

endmodule

// File: tb/tb_sync_box.sv
// Directed bench for sync_box: arbitration, LL/SC reservations, init release, watchdog, reset.
module tb_sync_box;
   import sync_box_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;

   sync_box_if #(.ADDR_W(32)) bus ();

   sync_box #(.ADDR_W(32), .RES_LSB(2), .WDOG_W(8)) u_dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_P0 = 0; bus.req_P1 = 0; bus.trigger_P0 = 0; bus.trigger_P1 = 0;
      bus.instr_type_P0 = IT_PLAIN; bus.instr_type_P1 = IT_PLAIN;
      bus.MAR_P0 = '0; bus.MAR_P1 = '0; bus.WR_N_P0 = 1; bus.WR_N_P1 = 1;
      bus.P0_mem_complete = 0; bus.P1_mem_complete = 0;
      bus.P0_in_init = 0; bus.P1_in_init = 0;
   endtask

   // Stimulus only: request, wait for grant, optional SC trigger, then complete.
   task automatic access(input int c, input itype_t it, input logic [31:0] addr,
                         input logic wr_n, input bit trig, output bit got, output logic succ);
      got = 0; succ = 0;
      if (c == 0) begin
         bus.req_P0 = 1; bus.instr_type_P0 = it; bus.MAR_P0 = addr; bus.WR_N_P0 = wr_n;
      end else begin
         bus.req_P1 = 1; bus.instr_type_P1 = it; bus.MAR_P1 = addr; bus.WR_N_P1 = wr_n;
      end
      for (int i = 0; i < 20; i++) begin
         step();
         if ((c == 0) ? bus.P0_pass : bus.P1_pass) begin
            got = 1;
            break;
         end
      end
      bus.req_P0 = 0; bus.req_P1 = 0;
      if (!got) return;
      if (trig) begin
         if (c == 0) bus.trigger_P0 = 1; else bus.trigger_P1 = 1;
         step();
         bus.trigger_P0 = 0; bus.trigger_P1 = 0;
         succ = (c == 0) ? bus.P0_success : bus.P1_success;
      end
      if (c == 0) bus.P0_mem_complete = 1; else bus.P1_mem_complete = 1;
      step();
      bus.P0_mem_complete = 0; bus.P1_mem_complete = 0;
      bus.instr_type_P0 = IT_PLAIN; bus.instr_type_P1 = IT_PLAIN;
      bus.WR_N_P0 = 1; bus.WR_N_P1 = 1;
   endtask

   task automatic test_reset();
      logic [5:0] outs;
      idle_inputs();
      #2 reset = 0;
      #1;
      outs = {bus.P0_pass, bus.P1_pass, bus.P0_success, bus.P1_success, bus.mem_owner, bus.wdog_err};
      n_checks++;
      if (outs !== 6'b0) begin n_fail++; $display("FAIL reset_outputs: got %b expected 000000", outs); end
      step(); step();
      outs = {bus.P0_pass, bus.P1_pass, bus.P0_success, bus.P1_success, bus.mem_owner, bus.wdog_err};
      n_checks++;
      if (outs !== 6'b0) begin n_fail++; $display("FAIL reset_held: got %b expected 000000", outs); end
   endtask

   task automatic test_single_grant();
      reset = 1;                 // cycle 0
      step(); step(); step();    // cycle 3
      bus.req_P0 = 1;
      n_checks++;
      if (bus.P0_pass !== 1'b0) begin n_fail++; $display("FAIL t1_pass_early: got %b expected 0", bus.P0_pass); end
      step();                    // cycle 4
      n_checks++;
      if ({bus.P0_pass, bus.P1_pass, bus.mem_owner} !== 3'b100) begin
         n_fail++; $display("FAIL t1_grant: got %b expected 100", {bus.P0_pass, bus.P1_pass, bus.mem_owner});
      end
      bus.req_P0 = 0;
      step();                    // cycle 5
      n_checks++;
      if (bus.P0_pass !== 1'b1) begin n_fail++; $display("FAIL t1_pass_hold: got %b expected 1", bus.P0_pass); end
      step();                    // cycle 6
      bus.P0_mem_complete = 1;
      step();                    // cycle 7
      bus.P0_mem_complete = 0;
      n_checks++;
      if (bus.P0_pass !== 1'b0) begin n_fail++; $display("FAIL t1_release: got %b expected 0", bus.P0_pass); end
   endtask

   task automatic test_back_to_back();
      int e;
      reset = 0; step(); reset = 1; step();
      bus.req_P0 = 1; bus.req_P1 = 1;
      e = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if ({bus.P0_pass, bus.P1_pass, bus.mem_owner} !== ((e == 0) ? 3'b100 : 3'b011)) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got %b expected core %0d", i, {bus.P0_pass, bus.P1_pass, bus.mem_owner}, e);
         end
         step();
         if (e == 0) bus.P0_mem_complete = 1; else bus.P1_mem_complete = 1;
         step();
         bus.P0_mem_complete = 0; bus.P1_mem_complete = 0;
         n_checks++;
         if ({bus.P0_pass, bus.P1_pass} !== 2'b00) begin
            n_fail++; $display("FAIL rr_idle_gap%0d: got %b expected 00", i, {bus.P0_pass, bus.P1_pass});
         end
         e = 1 - e;
      end
      bus.req_P0 = 0; bus.req_P1 = 0;
      step();
   endtask

   task automatic test_ll_sc();
      bit got; logic s;
      access(0, IT_LL, 32'h100, 1, 0, got, s);
      access(0, IT_SC, 32'h100, 0, 1, got, s);
      n_checks++;
      if (!got || s !== 1'b1) begin n_fail++; $display("FAIL sc_first: got %b expected 1 (granted %0d)", s, got); end
      n_checks++;
      if (bus.P0_success !== 1'b0) begin n_fail++; $display("FAIL sc_clear_after_complete: got %b expected 0", bus.P0_success); end
      access(0, IT_SC, 32'h100, 0, 1, got, s);
      n_checks++;
      if (!got || s !== 1'b0) begin n_fail++; $display("FAIL sc_second: got %b expected 0 (granted %0d)", s, got); end
   endtask

   task automatic test_snoop();
      bit got; logic s;
      access(0, IT_LL, 32'h100, 1, 0, got, s);
      access(1, IT_PLAIN, 32'h102, 0, 0, got, s);
      access(0, IT_SC, 32'h100, 0, 1, got, s);
      n_checks++;
      if (!got || s !== 1'b0) begin n_fail++; $display("FAIL snoop_same_word: got %b expected 0", s); end
      access(0, IT_LL, 32'h100, 1, 0, got, s);
      access(1, IT_PLAIN, 32'h104, 0, 0, got, s);
      access(0, IT_SC, 32'h100, 0, 1, got, s);
      n_checks++;
      if (!got || s !== 1'b1) begin n_fail++; $display("FAIL snoop_other_word: got %b expected 1", s); end
      access(0, IT_LL, 32'h100, 1, 0, got, s);
      access(1, IT_PLAIN, 32'h100, 1, 0, got, s);
      access(0, IT_SC, 32'h100, 0, 1, got, s);
      n_checks++;
      if (!got || s !== 1'b1) begin n_fail++; $display("FAIL snoop_read_keeps: got %b expected 1", s); end
   endtask

   task automatic test_init();
      bit got; logic s;
      bus.req_P1 = 1;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin step(); got = bus.P1_pass; end
      n_checks++;
      if (!got) begin n_fail++; $display("FAIL init_p1_grant: got 0 expected 1"); end
      bus.req_P1 = 0; bus.req_P0 = 1;
      step();
      n_checks++;
      if ({bus.P0_pass, bus.P1_pass} !== 2'b01) begin
         n_fail++; $display("FAIL init_p0_waits: got %b expected 01", {bus.P0_pass, bus.P1_pass});
      end
      bus.P1_in_init = 1;
      step();
      n_checks++;
      if ({bus.P0_pass, bus.P1_pass} !== 2'b00) begin
         n_fail++; $display("FAIL init_release: got %b expected 00", {bus.P0_pass, bus.P1_pass});
      end
      step();
      n_checks++;
      if ({bus.P0_pass, bus.P1_pass, bus.mem_owner} !== 3'b100) begin
         n_fail++; $display("FAIL init_p0_next: got %b expected 100", {bus.P0_pass, bus.P1_pass, bus.mem_owner});
      end
      bus.req_P0 = 0; bus.P0_mem_complete = 1;
      step();
      bus.P0_mem_complete = 0; bus.req_P1 = 1;
      step(); step(); step();
      n_checks++;
      if (bus.P1_pass !== 1'b0) begin n_fail++; $display("FAIL init_req_ignored: got %b expected 0", bus.P1_pass); end
      bus.req_P1 = 0; bus.P1_in_init = 0;
      step();
      access(1, IT_LL, 32'h200, 1, 0, got, s);
      access(1, IT_SC, 32'h200, 0, 1, got, s);
      n_checks++;
      if (!got || s !== 1'b1) begin n_fail++; $display("FAIL p1_sc_ok: got %b expected 1", s); end
      access(1, IT_LL, 32'h200, 1, 0, got, s);
      bus.P1_in_init = 1; step(); bus.P1_in_init = 0;
      access(1, IT_SC, 32'h200, 0, 1, got, s);
      n_checks++;
      if (!got || s !== 1'b0) begin n_fail++; $display("FAIL init_clears_res: got %b expected 0", s); end
   endtask

   task automatic test_watchdog();
      int cnt;
      bit got; logic s;
      logic [5:0] outs;
      bus.req_P0 = 1;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin step(); got = bus.P0_pass; end
      bus.req_P0 = 0;
      n_checks++;
      if (!got || bus.wdog_err !== 1'b0) begin
         n_fail++; $display("FAIL wdog_start: granted %0d err %b expected 1/0", got, bus.wdog_err);
      end
      cnt = 0;
      for (int i = 0; i < 300 && bus.P0_pass; i++) begin cnt++; step(); end
      n_checks++;
      if (cnt != 255) begin n_fail++; $display("FAIL wdog_len: got %0d expected 255", cnt); end
      n_checks++;
      if ({bus.P0_pass, bus.wdog_err} !== 2'b01) begin
         n_fail++; $display("FAIL wdog_release: got %b expected 01", {bus.P0_pass, bus.wdog_err});
      end
      access(1, IT_PLAIN, 32'h0, 1, 0, got, s);
      n_checks++;
      if (bus.wdog_err !== 1'b1) begin n_fail++; $display("FAIL wdog_sticky: got %b expected 1", bus.wdog_err); end
      bus.req_P1 = 1;
      got = 0;
      for (int i = 0; i < 10 && !got; i++) begin step(); got = bus.P1_pass; end
      n_checks++;
      if (!got || bus.mem_owner !== 1'b1) begin n_fail++; $display("FAIL rst_pre_grant: got %b expected 1", bus.mem_owner); end
      #3 reset = 0;
      #1;
      outs = {bus.P0_pass, bus.P1_pass, bus.P0_success, bus.P1_success, bus.mem_owner, bus.wdog_err};
      n_checks++;
      if (outs !== 6'b0) begin n_fail++; $display("FAIL rst_mid_grant: got %b expected 000000", outs); end
      bus.req_P1 = 0;
      step();
      reset = 1;
      step();
   endtask

   initial begin
      test_reset();
      test_single_grant();
      test_back_to_back();
      test_ll_sc();
      test_snoop();
      test_init();
      test_watchdog();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
